// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button front end and the lock FSM downstream.
// Cycle defaults assume a 50 MHz system clock.
package button_debounce_pkg;

   localparam int unsigned DEBOUNCE_10MS_50MHZ = 32'd500_000;
   localparam int unsigned LONG_1S_50MHZ       = 32'd50_000_000;

   // Channel index of each button as wired into the lock FSM.
   typedef enum logic [1:0] {
      BTN_RESET = 2'd0,
      BTN_0     = 2'd1,
      BTN_1     = 2'd2
   } btn_idx_e;

   function automatic int unsigned cnt_width(input int unsigned max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchroniser, stable-count debounce filter,
// hold timer and registered press/release/long-press pulses.
module debounce_channel
   import button_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter int unsigned LONG_CYCLES     = LONG_1S_50MHZ,
   parameter int unsigned CNT_W           = cnt_width(LONG_1S_50MHZ)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldMax  = CNT_W'(LONG_CYCLES);

   logic             s1_q, s2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;

   // Any sample agreeing with the current level restarts the stable count.
   always_comb begin
      level_d   = level_q;
      deb_cnt_d = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s2_q != level_q) begin
         if (deb_cnt_q == DebLast) begin
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
         end
      end
   end

   // Hold timer saturates so long-press fires exactly once per press.
   always_comb begin
      hold_cnt_d = '0;
      long_d     = 1'b0;
      if (level_q) begin
         if (hold_cnt_q == HoldMax) begin
            hold_cnt_d = hold_cnt_q;
         end else begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
            long_d     = (hold_cnt_q == HoldLast);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         level_q    <= 1'b0;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         s1_q       <= btn_i;
         s2_q       <= s1_q;
         level_q    <= level_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button front end for the lock FSM: one independent
// debounce_channel per raw pushbutton, all outputs registered.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int unsigned N_BTN           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
   parameter int unsigned LONG_CYCLES     = LONG_1S_50MHZ
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_in_i,
   output logic [N_BTN-1:0] btn_level_o,
   output logic [N_BTN-1:0] press_pulse_o,
   output logic [N_BTN-1:0] release_pulse_o,
   output logic [N_BTN-1:0] long_press_o
);

   localparam int unsigned CNT_W = cnt_width(LONG_CYCLES);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .btn_i     (btn_in_i[g]),
         .level_o   (btn_level_o[g]),
         .press_o   (press_pulse_o[g]),
         .release_o (release_pulse_o[g]),
         .long_o    (long_press_o[g])
      );
   end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: window-based behavioural model checked every cycle,
// directed scenarios with literal edge expectations, then randomized traffic.
module tb_button_debounce;

   localparam int N    = 3;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int HSZ  = 8192;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_level_o, press_pulse_o, release_pulse_o, long_press_o;

   button_debounce #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (DEB),
      .LONG_CYCLES     (LONG)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .btn_in_i        (btn_in),
      .btn_level_o     (btn_level_o),
      .press_pulse_o   (press_pulse_o),
      .release_pulse_o (release_pulse_o),
      .long_press_o    (long_press_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int edge_n = 0;
   bit started = 1'b0;

   // Model state: raw samples seen at the filter input, per channel.
   bit           hist [N][HSZ];
   int           last_clr [N];
   int           held [N];
   logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
   logic [N-1:0] exp_level = '0, exp_press = '0, exp_release = '0, exp_long = '0;

   int press_cnt [N] = '{default: 0};
   int release_cnt [N] = '{default: 0};
   int long_cnt [N] = '{default: 0};
   int press_edge [N] = '{default: -1};
   int release_edge [N] = '{default: -1};
   int long_edge [N] = '{default: -1};

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic cmp_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
      end
   endtask

   // A level change is accepted once the last DEB filtered samples taken since
   // the previous acceptance (or reset) all disagree with the current level.
   always @(posedge clk) begin
      bit   ok;
      logic lp;
      edge_n++;
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0;
         exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
         for (int c = 0; c < N; c++) begin
            last_clr[c] = edge_n;
            held[c] = 0;
         end
         started = 1'b1;
      end else begin
         for (int c = 0; c < N; c++) begin
            hist[c][edge_n % HSZ] = m_s2[c];
            lp = m_lvl[c];
            exp_press[c] = 1'b0;
            exp_release[c] = 1'b0;
            ok = (edge_n - last_clr[c] >= DEB);
            for (int j = 0; j < DEB; j++)
               if (ok && hist[c][(edge_n - j) % HSZ] == lp) ok = 1'b0;
            if (ok) begin
               m_lvl[c] = ~lp;
               exp_press[c] = ~lp;
               exp_release[c] = lp;
               last_clr[c] = edge_n;
            end
            if (lp) held[c]++;
            else held[c] = 0;
            exp_long[c] = (held[c] == LONG);
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_in[c];
         end
         exp_level = m_lvl;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         cmp_vec("btn_level", btn_level_o, exp_level);
         cmp_vec("press_pulse", press_pulse_o, exp_press);
         cmp_vec("release_pulse", release_pulse_o, exp_release);
         cmp_vec("long_press", long_press_o, exp_long);
         for (int c = 0; c < N; c++) begin
            if (press_pulse_o[c] === 1'b1) begin press_cnt[c]++; press_edge[c] = edge_n; end
            if (release_pulse_o[c] === 1'b1) begin release_cnt[c]++; release_edge[c] = edge_n; end
            if (long_press_o[c] === 1'b1) begin long_cnt[c]++; long_edge[c] = edge_n; end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int k, k2, r;
      int bp [N];
      int br [N];
      int bl [N];
      int dur [N];

      // 1: reset, then idle
      reset = 1'b1;
      btn_in = '0;
      cycles(3);
      reset = 1'b0;
      settle();
      check("reset_level", int'(btn_level_o), 0);
      check("reset_press", int'(press_pulse_o), 0);
      cycles(50);
      settle();
      check("idle_presses", press_cnt[0] + press_cnt[1] + press_cnt[2], 0);
      check("idle_long", long_cnt[0] + long_cnt[1] + long_cnt[2], 0);

      // 2: clean press and release on channel 1
      bp = press_cnt; br = release_cnt;
      @(negedge clk);
      btn_in[1] = 1'b1;
      k = edge_n + 1;
      cycles(12);
      settle();
      check("clean_press_edge", press_edge[1], k + 5);
      check("clean_press_count", press_cnt[1] - bp[1], 1);
      check("clean_level", int'(btn_level_o), 3'b010);
      check("clean_other_press", (press_cnt[0] - bp[0]) + (press_cnt[2] - bp[2]), 0);
      @(negedge clk);
      btn_in[1] = 1'b0;
      k2 = edge_n + 1;
      cycles(10);
      settle();
      check("clean_release_edge", release_edge[1], k2 + 5);
      check("clean_release_count", release_cnt[1] - br[1], 1);

      // 3: bounce on channel 0
      bp = press_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         btn_in[0] = (i % 2 == 0);
      end
      k = edge_n + 1;
      cycles(12);
      settle();
      check("bounce_press_count", press_cnt[0] - bp[0], 1);
      check("bounce_press_edge", press_edge[0], k + 5);
      @(negedge clk);
      btn_in[0] = 1'b0;
      cycles(10);

      // 4: long press on channel 2
      bp = press_cnt; br = release_cnt; bl = long_cnt;
      @(negedge clk);
      btn_in[2] = 1'b1;
      k = edge_n + 1;
      cycles(40);
      btn_in[2] = 1'b0;
      k2 = edge_n + 1;
      cycles(10);
      settle();
      check("long_press_edge", press_edge[2], k + 5);
      check("long_fire_edge", long_edge[2], k + 25);
      check("long_fire_count", long_cnt[2] - bl[2], 1);
      check("long_release_edge", release_edge[2], k2 + 5);
      check("long_release_count", release_cnt[2] - br[2], 1);

      // 5: short press filtered out
      bp = press_cnt; br = release_cnt;
      @(negedge clk);
      btn_in[1] = 1'b1;
      cycles(3);
      btn_in[1] = 1'b0;
      cycles(12);
      settle();
      check("short_press_count", press_cnt[1] - bp[1], 0);
      check("short_release_count", release_cnt[1] - br[1], 0);
      check("short_level", int'(btn_level_o), 0);

      // 6: reset in the middle of a held press
      bp = press_cnt; br = release_cnt; bl = long_cnt;
      @(negedge clk);
      btn_in[1] = 1'b1;
      cycles(10);
      reset = 1'b1;
      r = edge_n + 1;
      @(negedge clk);
      reset = 1'b0;
      settle();
      check("midhold_level", int'(btn_level_o), 0);
      cycles(35);
      settle();
      check("midhold_press_edge", press_edge[1], r + 6);
      check("midhold_press_count", press_cnt[1] - bp[1], 2);
      check("midhold_release_count", release_cnt[1] - br[1], 0);
      check("midhold_long_edge", long_edge[1], r + 26);
      check("midhold_long_count", long_cnt[1] - bl[1], 1);
      @(negedge clk);
      btn_in[1] = 1'b0;
      cycles(10);

      // Randomized traffic: mix of bouncy short runs and long holds, rare resets.
      dur = '{default: 1};
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 299) == 0);
         for (int c = 0; c < N; c++) begin
            dur[c]--;
            if (dur[c] <= 0) begin
               btn_in[c] = 1'($urandom_range(0, 1));
               dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                                    : int'($urandom_range(3, 35));
            end
         end
      end
      @(negedge clk);
      reset = 1'b0;
      btn_in = '0;
      cycles(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Multi-channel front end for the push-button lock. Each raw pushbutton is synchronised, debounced with a stable-count filter, and turned into clean one-cycle press/release pulses plus a one-shot long-press pulse.
- Sits directly upstream of the lock FSM. Each press_pulse bit drives one FSM button input (e.g. bit 0 → reset, bit 1 → b0, bit 2 → b1).
- Replaces a bare synchroniser/edge detector so that contact bounce never produces multiple FSM steps.

Parameters:
- N_BTN, 3, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (10 ms at 50 MHz). Legal minimum is 2.
- LONG_CYCLES, 50000000, cycles a debounced press must be held before long_press fires (1 s at 50 MHz). Must exceed DEBOUNCE_CYCLES.
- CNT_W, $clog2(LONG_CYCLES+1), counter width. Derived; never overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; clock clk.
- btn_in  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- btn_level  out  N_BTN  debounced level per channel.
- press_pulse  out  N_BTN  one-cycle pulse on each debounced 0→1 transition.
- release_pulse  out  N_BTN  one-cycle pulse on each debounced 1→0 transition.
- long_press  out  N_BTN  one-cycle pulse when a press has been held LONG_CYCLES cycles since acceptance.

Behaviour:
- Reset: all synchroniser flops, counters and outputs are cleared to 0 on the clock edge where reset=1. The output value is 0 in the cycle after that edge. Reset mid-debounce or mid-hold discards partial counts; no pulse is emitted because of reset.
- Synchroniser: two flops per channel (s1, s2); s2 is the filtered input.
- Debounce counter (per channel):
  - If s2 != btn_level, the counter increments.
  - If s2 == btn_level, the counter clears to 0, so any bounce restarts the count.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: btn_level toggles, the counter clears, and press_pulse or release_pulse is registered high for exactly one cycle.
- Latency: a clean 0→1 on btn_in just before edge k gives btn_level=1 and press_pulse=1 after edge k+1+DEBOUNCE_CYCLES. Release has the same latency.
- Held after reset: a button already held when reset deasserts yields a normal press_pulse after the standard latency. This is intentional.
- Hold counter (per channel):
  - Counts while btn_level=1 and clears when btn_level=0.
  - long_press fires once on the edge where it reaches LONG_CYCLES, then saturates. There is no repeat.
  - Releasing before LONG_CYCLES gives no long_press.
- Debounce and hold counters are separate per channel. Implementations may share a register only if the behaviour is identical.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses. Arbitration (e.g. b0&b1 treated as invalid) belongs to the FSM, not here.
- A pulse never coincides with its opposite edge on the same channel. press_pulse and release_pulse are mutually exclusive per bit.
- All outputs are registered; there are no combinational paths from btn_in.

Decomposition:
- Shared package/header: default cycle constants (DEBOUNCE_10MS_50MHZ, LONG_1S_50MHZ) and the button index constants (BTN_RESET=0, BTN_0=1, BTN_1=2) also used by the lock FSM.
- One sub-module, debounce_channel: single-bit synchroniser, debounce counter, hold counter and pulse flops. Top level instantiates N_BTN copies with a generate loop.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_BTN=3):
1. Reset then idle with btn_in=000 for 50 cycles → all outputs 0 throughout.
2. Clean press: btn_in[1] 0→1 before edge k and held → press_pulse=010 for one cycle after edge k+5, btn_level[1]=1 from then on, no other pulses.
3. Bounce: btn_in[0] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → exactly one press_pulse[0], 5 edges after the final rising transition; never during the bounce.
4. Long press: hold btn_in[2] for 40 cycles → press_pulse[2] once, long_press[2] once exactly 20 edges after press_pulse[2], no repeat. Release → release_pulse[2] 5 edges later.
5. Short press: hold 3 cycles then release → no press_pulse, no release_pulse, btn_level stays 0.
6. Reset mid-hold: assert reset for 1 cycle 10 cycles into a held press → btn_level=0 and no release_pulse. Button still held → new press_pulse 5 edges after reset deasserts (DEBOUNCE_CYCLES=4 after the synchroniser refills), and no long_press until 20 edges after that press_pulse.
